// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-low.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] CTRL_OFF = 4'hF;

    // Hex glyphs 0-F with the decimal point off
    localparam logic [7:0] HEX_SEG [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-segment decoder; a blanked digit keeps only its dp.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] segs
);

    logic [7:0] glyph_s;

    assign glyph_s = HEX_SEG[nibble];

    // Select glyph or blank for a-g, then apply the decimal point
    always_comb begin
        segs = SEG_OFF;
        if (blank) begin
            segs[7:1] = 7'h7F;
        end else begin
            segs[7:1] = glyph_s[7:1];
        end
        segs[0] = ~dp;
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed scan controller with per-slot blanking gap and
// frame-synchronous input shadowing to avoid tearing.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  ssd_ctrl,
    output logic [7:0]  ssd_out,
    output logic [1:0]  scan_idx,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    state_t      state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]  idx_r, idx_s;
    logic [15:0] sh_digits_r, sh_digits_s;
    logic [3:0]  sh_dp_r, sh_dp_s;
    logic        sh_lz_r, sh_lz_s;
    logic        frame_s;

    logic [3:0]  ctrl_r;
    logic [7:0]  segs_r;
    logic        frame_done_r;

    logic [3:0]  nib_s;
    logic        dp_s;
    logic        blank_s;
    logic [7:0]  seg_s;

    // Next-state, slot counter, digit index and shadow reload
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        sh_digits_s = sh_digits_r;
        sh_dp_s     = sh_dp_r;
        sh_lz_s     = sh_lz_r;
        frame_s     = 1'b0;
        if (!en) begin
            state_s = IDLE;
            cnt_s   = '0;
            idx_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s     = SLOT_START;
                    cnt_s       = '0;
                    idx_s       = 2'd0;
                    sh_digits_s = digits_in;
                    sh_dp_s     = dp_in;
                    sh_lz_s     = blank_lz;
                end
                BLANK, SHOW: begin
                    if (cnt_r == SLOT_LAST) begin
                        state_s = SLOT_START;
                        cnt_s   = '0;
                        idx_s   = idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            frame_s     = 1'b1;
                            sh_digits_s = digits_in;
                            sh_dp_s     = dp_in;
                            sh_lz_s     = blank_lz;
                        end else begin
                            frame_s = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                        if ((state_r == BLANK) && (cnt_r == BLANK_LAST)) begin
                            state_s = SHOW;
                        end else begin
                            state_s = state_r;
                        end
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    idx_s   = 2'd0;
                end
            endcase
        end
    end

    // Pick the digit for the upcoming cycle; a digit is a leading zero only
    // when it and every digit to its left are zero
    always_comb begin
        nib_s   = sh_digits_s[{idx_s, 2'b00} +: 4];
        dp_s    = sh_dp_s[idx_s];
        blank_s = 1'b0;
        case (idx_s)
            2'd3:    blank_s = sh_lz_s && (sh_digits_s[15:12] == 4'h0);
            2'd2:    blank_s = sh_lz_s && (sh_digits_s[15:8] == 8'h00);
            2'd1:    blank_s = sh_lz_s && (sh_digits_s[15:4] == 12'h000);
            default: blank_s = 1'b0;
        endcase
    end

    ssd_hex_decoder u_dec (
        .nibble (nib_s),
        .dp     (dp_s),
        .blank  (blank_s),
        .segs   (seg_s)
    );

    // Scan state, counter and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            idx_r       <= 2'd0;
            sh_digits_r <= 16'h0000;
            sh_dp_r     <= 4'h0;
            sh_lz_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            sh_digits_r <= sh_digits_s;
            sh_dp_r     <= sh_dp_s;
            sh_lz_r     <= sh_lz_s;
        end
    end

    // Registered pin drivers, aligned with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r       <= CTRL_OFF;
            segs_r       <= SEG_OFF;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_s;
            case (state_s)
                SHOW: begin
                    ctrl_r <= digit_enable(idx_s);
                    segs_r <= seg_s;
                end
                BLANK: begin
                    ctrl_r <= CTRL_OFF;
                    segs_r <= seg_s;
                end
                default: begin
                    ctrl_r <= CTRL_OFF;
                    segs_r <= SEG_OFF;
                end
            endcase
        end
    end

    assign ssd_ctrl   = ctrl_r;
    assign ssd_out    = segs_r;
    assign scan_idx   = idx_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: a blanking instance and a no-blanking instance
// share stimulus and are checked against a tick-count model every cycle.
module tb_ssd_scan_ctrl;

    localparam int DIV = 8;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [3:0] ctrl0, ctrl1;
    logic [7:0] segs0, segs1;
    logic [1:0] idx0, idx1;
    logic       fd0, fd1;

    int checks   = 0;
    int failures = 0;
    int off_while_run1 = 0;
    bit cmp_on = 1'b0;

    // model: position in the scan expressed as ticks since capture
    bit          mrun = 1'b0;
    int          mtick = 0;
    logic [15:0] msd = 16'h0;
    logic [3:0]  mdp = 4'h0;
    bit          mlz = 1'b0;

    ssd_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .ssd_ctrl(ctrl0),
        .ssd_out(segs0), .scan_idx(idx0), .frame_done(fd0)
    );

    ssd_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .ssd_ctrl(ctrl1),
        .ssd_out(segs1), .scan_idx(idx1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
            4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
            4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
            4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
        endcase
    endfunction

    function automatic int m_idx();
        return mrun ? (mtick / DIV) % 4 : 0;
    endfunction

    function automatic logic [3:0] exp_ctrl(input int blank_cyc);
        if (!mrun || (mtick % DIV) < blank_cyc) return 4'hF;
        return ~(4'b0001 << m_idx());
    endfunction

    function automatic logic [7:0] exp_segs();
        int i;
        logic [15:0] upper;
        logic [7:0] s;
        if (!mrun) return 8'hFF;
        i = m_idx();
        upper = msd >> (4 * i);
        s = (mlz && i > 0 && upper == 16'h0) ? 8'hFF : glyph(upper[3:0]);
        if (mdp[i]) s[0] = 1'b0;
        return s;
    endfunction

    function automatic logic exp_fd();
        return mrun && mtick > 0 && (mtick % (4 * DIV)) == 0;
    endfunction

    // behavioural model of the scan timeline
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrun <= 1'b0; mtick <= 0; msd <= 16'h0; mdp <= 4'h0; mlz <= 1'b0;
        end else if (!en) begin
            mrun <= 1'b0;
        end else if (!mrun) begin
            mrun <= 1'b1; mtick <= 0; msd <= digits_in; mdp <= dp_in; mlz <= blank_lz;
        end else begin
            mtick <= mtick + 1;
            if (((mtick + 1) % (4 * DIV)) == 0) begin
                msd <= digits_in; mdp <= dp_in; mlz <= blank_lz;
            end
        end
    end

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ctrl_b2", ctrl0, exp_ctrl(2));
            chk("segs_b2", segs0, exp_segs());
            chk("idx_b2",  idx0,  m_idx());
            chk("fd_b2",   fd0,   exp_fd());
            chk("ctrl_b0", ctrl1, exp_ctrl(0));
            chk("segs_b0", segs1, exp_segs());
            chk("idx_b0",  idx1,  m_idx());
            chk("fd_b0",   fd1,   exp_fd());
            if (mrun && ctrl1 == 4'hF) off_while_run1++;
        end
    end

    task automatic goto_tick(input int t);
        int n = 0;
        while (!(mrun && mtick == t) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(mrun && mtick == t)) begin
            failures++;
            $display("FAIL goto_tick timeout waiting for tick %0d", t);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; digits_in = 16'h1208; dp_in = 4'h0; blank_lz = 1'b0;
        #1 cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", ctrl0, 4'hF);
        chk("reset_segs", segs0, 8'hFF);
        chk("reset_idx", idx0, 2'd0);
        chk("reset_fd", fd0, 1'b0);

        en = 1'b1;
        goto_tick(0);
        chk("gap_ctrl", ctrl0, 4'hF);
        chk("gap_segs", segs0, 8'h01);
        chk("nogap_ctrl", ctrl1, 4'hE);
        goto_tick(2);  chk("d0_ctrl", ctrl0, 4'hE); chk("d0_segs", segs0, 8'h01);
        goto_tick(10); chk("d1_ctrl", ctrl0, 4'hD); chk("d1_segs", segs0, 8'h03);
        goto_tick(18); chk("d2_ctrl", ctrl0, 4'hB); chk("d2_segs", segs0, 8'h25);
        goto_tick(26); chk("d3_ctrl", ctrl0, 4'h7); chk("d3_segs", segs0, 8'h9F);

        goto_tick(28); digits_in = 16'hBEEF;
        goto_tick(31); chk("shadow_hold", segs0, 8'h9F); chk("fd_low", fd0, 1'b0);
        goto_tick(32); chk("fd_pulse", fd0, 1'b1); chk("fd_idx", idx0, 2'd0);
        goto_tick(33); chk("fd_one_cycle", fd0, 1'b0);
        goto_tick(34); chk("shadow_new", segs0, 8'h71);
        goto_tick(42); chk("shadow_d1", segs0, 8'h61);

        goto_tick(44); digits_in = 16'h0050; blank_lz = 1'b1; dp_in = 4'b1000;
        goto_tick(50); chk("mid_frame_hold", segs0, 8'h61);
        goto_tick(64); chk("nogap_d0", ctrl1, 4'hE);
        goto_tick(66); chk("lz_d0", segs0, 8'h03);
        goto_tick(71); chk("nogap_d0_end", ctrl1, 4'hE);
        goto_tick(72); chk("nogap_d1", ctrl1, 4'hD);
        goto_tick(74); chk("lz_d1", segs0, 8'h49);
        goto_tick(82); chk("lz_d2", segs0, 8'hFF); chk("lz_d2_ctrl", ctrl0, 4'hB);
        goto_tick(90); chk("lz_d3", segs0, 8'hFE); chk("lz_d3_ctrl", ctrl0, 4'h7);

        goto_tick(115);
        chk("slot2_pos3", ctrl0, 4'hB);
        en = 1'b0;
        @(negedge clk);
        chk("drop_ctrl", ctrl0, 4'hF); chk("drop_segs", segs0, 8'hFF);
        chk("drop_idx", idx0, 2'd0); chk("drop_ctrl_b0", ctrl1, 4'hF);
        digits_in = 16'h1208; blank_lz = 1'b0; dp_in = 4'b0001;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("restart_idx", idx0, 2'd0); chk("restart_segs", segs0, 8'h00);
        chk("restart_gap", ctrl0, 4'hF);
        repeat (2) @(negedge clk);
        chk("restart_d0", ctrl0, 4'hE);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0; en = 1'b0;
        #1;
        chk("async_ctrl", ctrl0, 4'hF); chk("async_segs", segs0, 8'hFF);
        chk("async_idx", idx0, 2'd0); chk("async_ctrl_b0", ctrl1, 4'hF);
        chk("async_segs_b0", segs1, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("off_ctrl", ctrl0, 4'hF); chk("off_segs", segs0, 8'hFF);
        chk("off_fd", fd0, 1'b0);
        chk("nogap_never_off", off_while_run1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
